// File: rtl/tri_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tri_bus_arbiter
//
// Round-robin arbiter and sequencer for a shared tri-state data bus. It grants
// the bus to one requester at a time and drives the per-device output enables.
// Between two owners it floats the bus for TURN_CYCLES cycles, so two drivers
// never overlap. The resolved bus value is presented on bus_data.
//
// Optional feature: define TRI_BUS_ARB_PARK_EN to compile in bus parking.
// A release with no other request pending then leaves the last owner driving
// the bus (PARK), and that owner can be re-granted without a turnaround.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   req       in   [NUM_DEV]        per-device level request
//   dev_data  in   [NUM_DEV*WIDTH]  packed device drive values, slice i = dev i
//   gnt       out  [NUM_DEV]        one-hot grant (registered)
//   oe        out  [NUM_DEV]        one-hot driver enable (registered)
//   bus_data  out  [WIDTH]          resolved bus value, reads 0 when floating
//   owner     out  [clog2(NUM_DEV)] index of the last or current owner
//   busy      out                   high while any oe bit is set
// -----------------------------------------------------------------------------
module tri_bus_arbiter #(
  parameter int NUM_DEV     = 4,
  parameter int WIDTH       = 8,
  parameter int MAX_HOLD    = 16,
  parameter int TURN_CYCLES = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_DEV-1:0]         req,
  input  logic [NUM_DEV*WIDTH-1:0]   dev_data,
  output logic [NUM_DEV-1:0]         gnt,
  output logic [NUM_DEV-1:0]         oe,
  output logic [WIDTH-1:0]           bus_data,
  output logic [$clog2(NUM_DEV)-1:0] owner,
  output logic                       busy
);

  localparam int OW_W = $clog2(NUM_DEV);
  localparam int HC_W = $clog2(MAX_HOLD + 1);
  localparam int TC_W = $clog2(TURN_CYCLES + 1);
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(MAX_HOLD - 1);
  localparam logic [TC_W-1:0] TURN_LAST = TC_W'(TURN_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
`ifdef TRI_BUS_ARB_PARK_EN
    ST_PARK,
`endif
    ST_TURN
  } state_t;

  state_t               state_q, state_d;
  logic [OW_W-1:0]      owner_q, owner_d;
  logic [HC_W-1:0]      hold_q, hold_d;
  logic [TC_W-1:0]      turn_q, turn_d;
  logic [NUM_DEV-1:0]   gnt_q, gnt_d;
  logic [NUM_DEV-1:0]   oe_q, oe_d;
  logic                 busy_q, busy_d;

  logic [OW_W-1:0]      winner;
  logic [NUM_DEV-1:0]   cur_1h;
  logic [NUM_DEV-1:0]   next_1h;
  logic                 others_pending;

  // Round-robin search: first set request strictly after the current owner,
  // wrapping, so the current owner is always considered last.
  always_comb begin
    int   idx;
    logic found;
    winner = owner_q;
    found  = 1'b0;
    for (int k = 1; k <= NUM_DEV; k++) begin
      idx = (int'(owner_q) + k) % NUM_DEV;
      if (!found && req[idx]) begin
        winner = OW_W'(idx);
        found  = 1'b1;
      end
    end
  end

  assign cur_1h         = NUM_DEV'(1) << owner_q;
  assign others_pending = |(req & ~cur_1h);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    hold_d  = hold_q;
    turn_d  = turn_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d = ST_GRANT;
          owner_d = winner;
          hold_d  = '0;
        end
      end
      ST_GRANT: begin
        if (!req[owner_q] || hold_q == HOLD_LAST) begin
          turn_d = '0;
`ifdef TRI_BUS_ARB_PARK_EN
          state_d = others_pending ? ST_TURN : ST_PARK;
`else
          state_d = ST_TURN;
`endif
        end else begin
          hold_d = hold_q + HC_W'(1);
        end
      end
      ST_TURN: begin
        if (turn_q == TURN_LAST) begin
          // Last float cycle doubles as the IDLE arbitration cycle so a
          // pending request is granted without an extra bubble.
          turn_d = '0;
          if (|req) begin
            state_d = ST_GRANT;
            owner_d = winner;
            hold_d  = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          turn_d = turn_q + TC_W'(1);
        end
      end
`ifdef TRI_BUS_ARB_PARK_EN
      ST_PARK: begin
        // Another device takes precedence over a re-request by the parked
        // owner, so the parked owner cannot starve the others.
        if (others_pending) begin
          state_d = ST_TURN;
          turn_d  = '0;
        end else if (req[owner_q]) begin
          state_d = ST_GRANT;
          hold_d  = '0;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they come straight off flops.
  assign next_1h = NUM_DEV'(1) << owner_d;

  always_comb begin
    gnt_d = '0;
    oe_d  = '0;
    if (state_d == ST_GRANT) begin
      gnt_d = next_1h;
      oe_d  = next_1h;
    end
`ifdef TRI_BUS_ARB_PARK_EN
    if (state_d == ST_PARK) begin
      oe_d = next_1h;
    end
`endif
    busy_d = |oe_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= OW_W'(NUM_DEV - 1);
      hold_q  <= '0;
      turn_q  <= '0;
      gnt_q   <= '0;
      oe_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
      turn_q  <= turn_d;
      gnt_q   <= gnt_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
    end
  end

  // Shared bus: pulled to 0 when no device drives it.
  tri0 [WIDTH-1:0] bus;

  generate
    for (genvar gi = 0; gi < NUM_DEV; gi++) begin : g_drv
      assign bus = oe_q[gi] ? dev_data[gi*WIDTH +: WIDTH] : 'z;
    end
  endgenerate

  assign bus_data = bus;
  assign gnt      = gnt_q;
  assign oe       = oe_q;
  assign owner    = owner_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_tri_bus_arbiter.sv
module tb_tri_bus_arbiter;

  localparam int NUM_DEV = 4;
  localparam int WIDTH   = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] dev_data;
  logic [3:0]  gnt;
  logic [3:0]  oe;
  logic [7:0]  bus_data;
  logic [1:0]  owner;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tri_bus_arbiter #(
    .NUM_DEV    (NUM_DEV),
    .WIDTH      (WIDTH),
    .MAX_HOLD   (16),
    .TURN_CYCLES(1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .dev_data(dev_data),
    .gnt     (gnt),
    .oe      (oe),
    .bus_data(bus_data),
    .owner   (owner),
    .busy    (busy)
  );

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic [3:0] oe;
    logic [7:0] bus;
    logic [1:0] owner;
    logic       busy;
  } vec_t;

  vec_t tbl [14];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp_v);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] eg, input logic [3:0] eo,
                         input logic [7:0] eb, input logic [1:0] ew, input logic eby);
    $display("%s req=%b gnt=%b oe=%b bus=%h owner=%0d busy=%b",
             tag, req, gnt, oe, bus_data, owner, busy);
    chk({tag, ".gnt"},   32'(gnt),      32'(eg));
    chk({tag, ".oe"},    32'(oe),       32'(eo));
    chk({tag, ".bus"},   32'(bus_data), 32'(eb));
    chk({tag, ".owner"}, 32'(owner),    32'(ew));
    chk({tag, ".busy"},  32'(busy),     32'(eby));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_oe;
    logic [7:0] exp_bus;
    int         pos;
    int         slot;

    // dev3=C3, dev2=3C, dev1=A5, dev0=5A
    dev_data = 32'hC3_3C_A5_5A;

    //                req      gnt      oe       bus    own  busy
    tbl[0]  = '{4'b0000, 4'b0000, 4'b0000, 8'h00, 2'd3, 1'b0};
    tbl[1]  = '{4'b0110, 4'b0010, 4'b0010, 8'hA5, 2'd1, 1'b1};
    tbl[2]  = '{4'b0110, 4'b0010, 4'b0010, 8'hA5, 2'd1, 1'b1};
    tbl[3]  = '{4'b0100, 4'b0000, 4'b0000, 8'h00, 2'd1, 1'b0};
    tbl[4]  = '{4'b0100, 4'b0100, 4'b0100, 8'h3C, 2'd2, 1'b1};
    tbl[5]  = '{4'b1000, 4'b0000, 4'b0000, 8'h00, 2'd2, 1'b0};
    tbl[6]  = '{4'b1000, 4'b1000, 4'b1000, 8'hC3, 2'd3, 1'b1};
    tbl[7]  = '{4'b1001, 4'b1000, 4'b1000, 8'hC3, 2'd3, 1'b1};
    tbl[8]  = '{4'b0001, 4'b0000, 4'b0000, 8'h00, 2'd3, 1'b0};
    tbl[9]  = '{4'b0001, 4'b0001, 4'b0001, 8'h5A, 2'd0, 1'b1};
    tbl[10] = '{4'b0011, 4'b0001, 4'b0001, 8'h5A, 2'd0, 1'b1};
    tbl[11] = '{4'b0010, 4'b0000, 4'b0000, 8'h00, 2'd0, 1'b0};
    tbl[12] = '{4'b0010, 4'b0010, 4'b0010, 8'hA5, 2'd1, 1'b1};
    tbl[13] = '{4'b1010, 4'b0010, 4'b0010, 8'hA5, 2'd1, 1'b1};

    // Reset state, sampled while reset is still asserted.
    rst = 1'b1;
    req = 4'b0110;
    step();
    step();
    chk_all("in_reset", 4'b0000, 4'b0000, 8'h00, 2'd3, 1'b0);
    rst = 1'b0;

    // Directed vector table.
    for (int i = 0; i < 14; i++) begin
      req = tbl[i].req;
      step();
      chk_all($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].oe, tbl[i].bus,
              tbl[i].owner, tbl[i].busy);
    end

    // Full contention: 16-cycle holds with one float cycle, rotating 0,1,2,3,0.
    do_reset();
    req = 4'b1111;
    for (int c = 0; c < 4 * 17 + 16; c++) begin
      step();
      pos  = c % 17;
      slot = (c / 17) % 4;
      exp_oe  = (pos < 16) ? 4'(1 << slot) : 4'b0000;
      exp_bus = (pos < 16) ? dev_data[slot*8 +: 8] : 8'h00;
      if (pos == 0) begin
        $display("rot grant slot=%0d gnt=%b owner=%0d", c / 17, gnt, owner);
      end
      chk($sformatf("rot%0d.gnt", c), 32'(gnt), 32'(exp_oe));
      chk($sformatf("rot%0d.oe", c), 32'(oe), 32'(exp_oe));
      chk($sformatf("rot%0d.bus", c), 32'(bus_data), 32'(exp_bus));
      chk($sformatf("rot%0d.onehot", c), 32'($countones(oe) <= 1), 32'd1);
      chk($sformatf("rot%0d.known", c), 32'($isunknown(bus_data)), 32'd0);
    end

    // Reset in the middle of a dev2 grant, then dev2 alone again.
    do_reset();
    req = 4'b0100;
    step();
    chk_all("mid.grant", 4'b0100, 4'b0100, 8'h3C, 2'd2, 1'b1);
    step();
    rst = 1'b1;
    step();
    chk_all("mid.rst", 4'b0000, 4'b0000, 8'h00, 2'd3, 1'b0);
    rst = 1'b0;
    step();
    chk_all("mid.regrant", 4'b0100, 4'b0100, 8'h3C, 2'd2, 1'b1);

    // Dev0 alone: release, re-request, release, then dev3 requests.
    do_reset();
    req = 4'b0001;
    step();
    chk_all("park.g0", 4'b0001, 4'b0001, 8'h5A, 2'd0, 1'b1);
    step();
    req = 4'b0000;
    step();
`ifdef TRI_BUS_ARB_PARK_EN
    chk_all("park.rel", 4'b0000, 4'b0001, 8'h5A, 2'd0, 1'b1);
    step();
    chk_all("park.hold", 4'b0000, 4'b0001, 8'h5A, 2'd0, 1'b1);
`else
    chk_all("park.rel", 4'b0000, 4'b0000, 8'h00, 2'd0, 1'b0);
    step();
    chk_all("park.idle", 4'b0000, 4'b0000, 8'h00, 2'd0, 1'b0);
`endif
    req = 4'b0001;
    step();
    chk_all("park.rereq", 4'b0001, 4'b0001, 8'h5A, 2'd0, 1'b1);
    req = 4'b0000;
    step();
    req = 4'b1000;
    step();
`ifdef TRI_BUS_ARB_PARK_EN
    chk_all("park.float", 4'b0000, 4'b0000, 8'h00, 2'd0, 1'b0);
    step();
`endif
    chk_all("park.g3", 4'b1000, 4'b1000, 8'hC3, 2'd3, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
